// File: rtl/alu_mdu_if.sv
// Request/response bundle between the datapath control and alu_mdu.
// The master drives the request; the slave returns the registered results and HI/LO.
interface alu_mdu_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [4:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b,
    input  busy, done, result, zero, overflow, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b,
    output busy, done, result, zero, overflow, hi, lo
  );
endinterface

// File: rtl/alu_mdu.sv
// Registered ALU with an iterative multiply/divide unit and architectural HI/LO.
// state | meaning:  IDLE single-cycle ops / accept MDU | CALC one mul/div step per cycle | FIX sign fix, write HI/LO
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst_n,
  alu_mdu_if.slave  bus
);
  localparam int SH_W = $clog2(WIDTH);

  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,  OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4,  OP_NOR  = 5'd5,  OP_SLT  = 5'd6,  OP_SLTU = 5'd7;
  localparam logic [4:0] OP_SLL = 5'd8,  OP_SRL  = 5'd9,  OP_SRA  = 5'd10, OP_LU   = 5'd11;
  localparam logic [4:0] OP_MFHI = 5'd16, OP_MFLO = 5'd17, OP_MTHI = 5'd18, OP_MTLO = 5'd19;

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIX} state_t;

  state_t            state_q, state_d;
  logic [SH_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  acc_q, acc_d, mq_q, mq_d, opb_q, opb_d;
  logic              is_div_q, is_div_d, neg_q, neg_d, sa_q, sa_d, bz_q, bz_d;
  logic [WIDTH-1:0]  result_q, result_d, hi_q, hi_d, lo_q, lo_d;
  logic              zero_q, zero_d, ovf_q, ovf_d, done_q, done_d;

  logic [WIDTH-1:0]   sum_w, diff_w, alu_res, mag_a, mag_b, quo_fix, rem_fix, fix_lo;
  logic [SH_W-1:0]    shamt;
  logic               alu_ovf, signed_op;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_mag, prod_fix;

  always_comb begin
    sum_w   = bus.src_a + bus.src_b;
    diff_w  = bus.src_a - bus.src_b;
    shamt   = bus.src_a[SH_W-1:0];
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_res = sum_w;
        alu_ovf = (bus.src_a[WIDTH-1] == bus.src_b[WIDTH-1]) && (sum_w[WIDTH-1] != bus.src_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff_w;
        alu_ovf = (bus.src_a[WIDTH-1] != bus.src_b[WIDTH-1]) && (diff_w[WIDTH-1] != bus.src_a[WIDTH-1]);
      end
      OP_AND:  alu_res = bus.src_a & bus.src_b;
      OP_OR:   alu_res = bus.src_a | bus.src_b;
      OP_XOR:  alu_res = bus.src_a ^ bus.src_b;
      OP_NOR:  alu_res = ~(bus.src_a | bus.src_b);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.src_a < bus.src_b)};
      OP_SLL:  alu_res = bus.src_b << shamt;
      OP_SRL:  alu_res = bus.src_b >> shamt;
      OP_SRA:  alu_res = $signed(bus.src_b) >>> shamt;
      OP_LU:   alu_res = {bus.src_b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      OP_MTHI, OP_MTLO: alu_res = bus.src_a;
      default: alu_res = '0;
    endcase
  end

  // Signed MDU ops run on magnitudes; signs are restored in FIX.
  always_comb begin
    signed_op = ~bus.op[0];
    mag_a     = (signed_op && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
    mag_b     = (signed_op && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;
    mul_sum   = {1'b0, acc_q} + {1'b0, (mq_q[0] ? opb_q : {WIDTH{1'b0}})};
    div_shift = {acc_q, mq_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    prod_mag  = {acc_q, mq_q};
    prod_fix  = neg_q ? -prod_mag : prod_mag;
    quo_fix   = bz_q ? {WIDTH{1'b1}} : (neg_q ? -mq_q : mq_q);
    rem_fix   = sa_q ? -acc_q : acc_q;
    fix_lo    = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    sa_d     = sa_q;
    bz_d     = bz_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.op[4:2] == 3'b011) begin
            is_div_d = bus.op[1];
            sa_d     = signed_op & bus.src_a[WIDTH-1];
            neg_d    = signed_op & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
            bz_d     = (bus.src_b == '0);
            acc_d    = '0;
            mq_d     = mag_a;
            opb_d    = mag_b;
            cnt_d    = SH_W'(WIDTH-1);
            state_d  = ST_CALC;
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            ovf_d    = alu_ovf;
            done_d   = 1'b1;
            if (bus.op == OP_MTHI) hi_d = bus.src_a;
            if (bus.op == OP_MTLO) lo_d = bus.src_a;
          end
        end
      end
      ST_CALC: begin
        if (is_div_q) begin
          if (!div_diff[WIDTH]) begin
            acc_d = div_diff[WIDTH-1:0];
            mq_d  = {mq_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = div_shift[WIDTH-1:0];
            mq_d  = {mq_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = mul_sum[WIDTH:1];
          mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) state_d = ST_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_FIX: begin
        hi_d     = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        lo_d     = fix_lo;
        result_d = fix_lo;
        zero_d   = (fix_lo == '0);
        ovf_d    = 1'b0;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      sa_q     <= 1'b0;
      bz_q     <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      sa_q     <= sa_d;
      bz_q     <= bz_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.zero     = zero_q;
  assign bus.overflow = ovf_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
endmodule

// File: tb/tb_alu_mdu.sv
// Randomized self-checking bench for alu_mdu (WIDTH=32 and WIDTH=16 instances)
// against an arithmetic reference model of the instruction set.
module tb_alu_mdu;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_mdu_if #(.WIDTH(32)) bus ();
  alu_mdu_if #(.WIDTH(16)) bus16 ();

  alu_mdu #(.WIDTH(32)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  alu_mdu #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));

  int n_err = 0;
  int n_chk = 0;
  logic [31:0] m_hi, m_lo;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Reference: what each op does to result/overflow and the architectural HI/LO.
  task automatic model_op(input logic [4:0] op, input logic [31:0] a, b,
                          output logic [31:0] res, output logic ovf);
    longint s, q, r;
    logic [63:0] p;
    res = 32'h0;
    ovf = 1'b0;
    case (op)
      0, 1: begin
        s = (op == 0) ? longint'($signed(a)) + longint'($signed(b))
                      : longint'($signed(a)) - longint'($signed(b));
        p = s;
        res = p[31:0];
        ovf = (s > longint'(32'h7FFF_FFFF)) || (s < -longint'(32'h8000_0000));
      end
      2:  res = a & b;
      3:  res = a | b;
      4:  res = a ^ b;
      5:  res = ~(a | b);
      6:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      7:  res = (a < b) ? 32'd1 : 32'd0;
      8:  res = b << a[4:0];
      9:  res = b >> a[4:0];
      10: res = $signed(b) >>> a[4:0];
      11: res = {b[15:0], 16'h0};
      12: begin p = longint'($signed(a)) * longint'($signed(b)); m_hi = p[63:32]; m_lo = p[31:0]; res = m_lo; end
      13: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; res = m_lo; end
      14: begin
        if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
        else begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          p = q; m_lo = p[31:0];
          p = r; m_hi = p[31:0];
        end
        res = m_lo;
      end
      15: begin
        if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
        else begin m_lo = a / b; m_hi = a % b; end
        res = m_lo;
      end
      16: res = m_hi;
      17: res = m_lo;
      18: begin m_hi = a; res = a; end
      19: begin m_lo = a; res = a; end
      default: res = 32'h0;
    endcase
  endtask

  task automatic run_op(input logic [4:0] op, input logic [31:0] a, b);
    logic [31:0] er;
    logic eo;
    int cyc, lat;
    lat = (op >= 12 && op <= 15) ? 34 : 1;
    model_op(op, a, b, er, eo);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    chk("busy", bus.busy, (lat > 1));
    while (!bus.done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, lat);
    chk("result", bus.result, er);
    chk("zero", bus.zero, (er == 0));
    chk("overflow", bus.overflow, eo);
    chk("hi", bus.hi, m_hi);
    chk("lo", bus.lo, m_lo);
    if (lat > 1) begin
      chk("busy_at_done", bus.busy, 0);
      @(negedge clk);
      chk("done_single", bus.done, 0);
    end
  endtask

  task automatic run_b2b(input int n);
    logic [31:0] er, a, b;
    logic eo;
    logic [4:0] op;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("b2b_done", bus.done, 1);
        chk("b2b_result", bus.result, er);
        chk("b2b_overflow", bus.overflow, eo);
      end
      if (i < n) begin
        do op = 5'($urandom_range(0, 31)); while (op >= 12 && op <= 15);
        a = rnd_val(); b = rnd_val();
        model_op(op, a, b, er, eo);
        bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
      end else begin
        bus.start = 1'b0;
      end
    end
    chk("b2b_hi", bus.hi, m_hi);
    chk("b2b_lo", bus.lo, m_lo);
  endtask

  task automatic run16(input logic [4:0] op, input logic [15:0] a, b);
    logic [31:0] p;
    logic [15:0] eh, el;
    int cyc;
    if (op == 13) begin p = {16'd0, a} * {16'd0, b}; eh = p[31:16]; el = p[15:0]; end
    else if (b == 0) begin eh = a; el = 16'hFFFF; end
    else begin el = a / b; eh = a % b; end
    @(negedge clk);
    bus16.start = 1'b1; bus16.op = op; bus16.src_a = a; bus16.src_b = b;
    @(negedge clk);
    bus16.start = 1'b0;
    cyc = 1;
    while (!bus16.done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("w16_latency", cyc, 18);
    chk("w16_hi", bus16.hi, eh);
    chk("w16_lo", bus16.lo, el);
    chk("w16_result", bus16.result, el);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, seen;
    logic [31:0] er;
    logic eo;
    logic [4:0] op;
    rst_n = 1'b0;
    bus.start = 1'b0;   bus.op = '0;   bus.src_a = '0;   bus.src_b = '0;
    bus16.start = 1'b0; bus16.op = '0; bus16.src_a = '0; bus16.src_b = '0;
    m_hi = 32'h0; m_lo = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_result", bus.result, 0);
    chk("rst_zero", bus.zero, 1);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    rst_n = 1'b1;

    run_op(5'd0, 32'h7FFF_FFFF, 32'h1);
    chk("add_c", bus.result, 32'h8000_0000);
    chk("add_ovf_c", bus.overflow, 1);
    run_op(5'd1, 32'd5, 32'd5);
    chk("sub_zero_c", bus.zero, 1);
    run_op(5'd10, 32'd4, 32'h8000_0000);
    chk("sra_c", bus.result, 32'hF800_0000);
    run_op(5'd6, 32'hFFFF_FFFF, 32'h1);
    chk("slt_c", bus.result, 32'h1);
    run_op(5'd7, 32'hFFFF_FFFF, 32'h1);
    chk("sltu_c", bus.result, 32'h0);
    run_op(5'd11, 32'h0, 32'h1234);
    chk("lu_c", bus.result, 32'h1234_0000);
    run_op(5'd12, 32'hFFFF_FFFF, 32'h2);
    chk("mult_hi_c", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo_c", bus.lo, 32'hFFFF_FFFE);
    run_op(5'd13, 32'hFFFF_FFFF, 32'h2);
    chk("multu_hi_c", bus.hi, 32'h1);
    run_op(5'd14, 32'hFFFF_FFF9, 32'h2);
    chk("div_lo_c", bus.lo, 32'hFFFF_FFFD);
    chk("div_hi_c", bus.hi, 32'hFFFF_FFFF);
    run_op(5'd14, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_min_lo_c", bus.lo, 32'h8000_0000);
    chk("div_min_hi_c", bus.hi, 32'h0);
    run_op(5'd14, 32'hFFFF_FFF9, 32'h0);
    chk("div0s_hi_c", bus.hi, 32'hFFFF_FFF9);
    run_op(5'd15, 32'd7, 32'd0);
    chk("divu0_lo_c", bus.lo, 32'hFFFF_FFFF);
    // MFHI in the cycle right after done
    run_op(5'd16, 32'h0, 32'h0);
    chk("mfhi_c", bus.result, 32'd7);

    // start during busy must be ignored
    model_op(5'd13, 32'h1234_5678, 32'h9ABC_DEF0, er, eo);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 5'd13; bus.src_a = 32'h1234_5678; bus.src_b = 32'h9ABC_DEF0;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    repeat (4) @(negedge clk);
    cyc = 5;
    bus.start = 1'b1; bus.op = 5'd0; bus.src_a = 32'h1; bus.src_b = 32'h1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 6;
    chk("ign_no_done", bus.done, 0);
    while (!bus.done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("ign_latency", cyc, 34);
    chk("ign_result", bus.result, er);
    chk("ign_hi", bus.hi, m_hi);
    @(negedge clk);
    chk("ign_no_extra_done", bus.done, 0);

    // reset in the middle of CALC
    @(negedge clk);
    bus.start = 1'b1; bus.op = 5'd13; bus.src_a = 32'hDEAD_BEEF; bus.src_b = 32'h3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_hi", bus.hi, 0);
    chk("mid_rst_lo", bus.lo, 0);
    m_hi = 32'h0; m_lo = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    chk("mid_rst_no_done", seen, 0);

    run_b2b(24);

    for (int i = 0; i < 120; i++) begin
      op = 5'($urandom_range(0, 31));
      run_op(op, rnd_val(), rnd_val());
    end

    run16(5'd13, 16'hFFFF, 16'hFFFF);
    chk("w16_hi_c", bus16.hi, 16'hFFFE);
    chk("w16_lo_c", bus16.lo, 16'h0001);
    for (int i = 0; i < 6; i++) begin
      run16((i % 2 == 0) ? 5'd13 : 5'd15, 16'($urandom), 16'($urandom_range(0, 300)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised, sequential successor to the datapath ALU for the multicycle CPU.
- Registers every result. Adds a start/done handshake and an iterative multiply/divide unit with architectural HI/LO registers.
- Sits in the datapath between the operand registers (A/B) and ALUOut. The control FSM stalls on `busy`.

Parameters:
- WIDTH, 32, datapath width in bits. Must be even and a power of two, ≥ 8.
- SH_W, $clog2(WIDTH), shift-amount width; derived, do not override.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; samples op/src_a/src_b
- op  in  5  operation code (encoding below)
- src_a  in  WIDTH  operand A; shift amount in [SH_W-1:0]
- src_b  in  WIDTH  operand B
- busy  out  1  high while a multiply/divide is in progress
- done  out  1  one-cycle pulse; result/zero/overflow valid this cycle and held until the next done
- result  out  WIDTH  registered result
- zero  out  1  result == 0, registered with result
- overflow  out  1  signed overflow for ADD/SUB, else 0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset: result=0, zero=1, overflow=0, done=0, busy=0, hi=0, lo=0, FSM=IDLE.
  - Reset asserted mid-operation aborts it; no done is produced.
- Op encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR
  - 6 SLT (signed), 7 SLTU, 8 SLL, 9 SRL, 10 SRA
  - 11 LU (b[WIDTH/2-1:0] into the upper half, lower half 0)
  - 12 MULT, 13 MULTU, 14 DIV, 15 DIVU
  - 16 MFHI, 17 MFLO, 18 MTHI (hi<=src_a), 19 MTLO (lo<=src_a)
  - 20-31 produce result=0.
- Shifts use b shifted by a[SH_W-1:0]. SRA is a true arithmetic shift.
- SLT/SLTU result is {0…0, flag}. All arithmetic is modulo 2^WIDTH.
- FSM states: IDLE, CALC, FIX.
- IDLE, start with op ∉ 12-15: result/zero/overflow registered and done=1 on the next cycle (latency 1). Back-to-back starts are allowed every cycle. MT* also pulse done; their result=src_a.
- IDLE, start with op 12-15:
  - Latch magnitudes (signed ops) or raw operands (unsigned ops).
  - Latch sign bits; busy=1 from the next cycle.
  - Go to CALC.
- CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, for exactly WIDTH cycles (counter WIDTH-1 down to 0), then FIX.
- FIX:
  - Apply sign correction and write hi/lo.
  - Multiply: {hi,lo} = 2·WIDTH-bit product.
  - Divide: lo = quotient, truncated toward zero; hi = remainder, with the sign of the dividend.
  - Next cycle: done=1, busy=0, result=lo, zero=(lo==0), state IDLE.
  - Total latency is start cycle N → done at N+WIDTH+2.
- Divide by zero: no trap. lo = all ones, hi = dividend (as given, unsigned or signed). Latency is unchanged.
- Signed DIV of the most negative value by -1: lo = most negative value, hi = 0.
- start while busy=1 is ignored: no state change and no done.
- MFHI/MFLO issued the cycle after done read the new hi/lo.
- done is never asserted in two consecutive cycles for a multiply/divide. For single-cycle ops it may be.
- hi/lo change only in FIX or on MTHI/MTLO.

Test Plan:
- Reset, then ADD a=0x7FFFFFFF b=1 → done at N+1: result=0x80000000, overflow=1, zero=0. SUB a=5 b=5 → result=0, zero=1.
- SRA a=4 b=0x80000000 → 0xF8000000. SLT a=0xFFFFFFFF b=1 → 1. SLTU with the same operands → 0. LU b=0x1234 → 0x12340000.
- MULT a=0xFFFFFFFF b=2 → busy for 33 cycles, done at N+34: hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands → hi=1, lo=0xFFFFFFFE.
- DIV a=-7 b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7 b=0 → lo=0xFFFFFFFF, hi=7. MFHI next cycle → result=7.
- start ADD during busy → ignored, no extra done. Assert rst_n=0 mid-CALC → busy=0, hi=lo=0 immediately, no done after release.
- WIDTH=16 instance: MULTU 0xFFFF·0xFFFF → hi=0xFFFE, lo=0x0001, done at N+18.
